// File: rtl/dout_pkg.sv
// Shared types for the digital output channel driver.
package dout_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_STATIC  = 2'b00,
        MODE_ONESHOT = 2'b01,
        MODE_PWM     = 2'b10,
        MODE_SAFE    = 2'b11
    } dout_mode_t;

endpackage

// File: rtl/dout_oneshot.sv
// Single-channel one-shot timer: busy flag, width counter and pulse qualifier.
module dout_oneshot
    import dout_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] width,
    output logic             busy,
    output logic             pulse
);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start;

    // An abort frees the channel, so a trigger on the same edge may still start.
    assign start = trig && (width != '0) && (abort || !busy_q);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = width;
        end else if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // busy stays high one edge past the last pulse cycle so it drops with the pin.
    assign busy  = busy_q;
    assign pulse = busy_q && (cnt_q != '0);

endmodule

// File: rtl/dout_channel_driver.sv
// Digital output pin driver: shadow/commit config, per-channel modes, shared PWM
// counter and a software watchdog that forces the safe pattern.
module dout_channel_driver
    import dout_pkg::*;
#(
    parameter int unsigned       NUM_CH     = 8,
    parameter int unsigned       CNT_W      = 32,
    parameter logic [NUM_CH-1:0] SAFE_VALUE = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [NUM_CH-1:0]        cfg_level,
    input  logic [MODE_W*NUM_CH-1:0] cfg_mode,
    input  logic [CNT_W-1:0]         cfg_width,
    input  logic [CNT_W-1:0]         cfg_period,
    input  logic                     cfg_commit,
    input  logic [NUM_CH-1:0]        trig,
    input  logic                     wd_enable,
    input  logic [CNT_W-1:0]         wd_timeout,
    input  logic                     wd_kick,
    input  logic                     wd_clear,
    output logic [NUM_CH-1:0]        dout,
    output logic [NUM_CH-1:0]        busy,
    output logic                     wd_fault
);

    logic [NUM_CH-1:0]        act_level_q;
    logic [MODE_W*NUM_CH-1:0] act_mode_q;
    logic [CNT_W-1:0]         act_width_q;
    logic [CNT_W-1:0]         act_period_q;

    logic [CNT_W-1:0]         pwm_cnt_q, pwm_cnt_d;
    logic [CNT_W-1:0]         wd_cnt_q, wd_cnt_d;
    logic                     wd_fault_q, wd_fault_d;
    logic [NUM_CH-1:0]        dout_q, dout_d;

    logic [MODE_W*NUM_CH-1:0] eff_mode;
    logic [CNT_W-1:0]         eff_width;
    logic [NUM_CH-1:0]        os_trig;
    logic [NUM_CH-1:0]        os_pulse;
    logic                     os_abort;
    logic                     pwm_out;
    logic                     wd_expire;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            act_level_q  <= SAFE_VALUE;
            act_mode_q   <= {NUM_CH{MODE_STATIC}};
            act_width_q  <= '0;
            act_period_q <= '0;
        end else if (cfg_commit) begin
            act_level_q  <= cfg_level;
            act_mode_q   <= cfg_mode;
            act_width_q  <= cfg_width;
            act_period_q <= cfg_period;
        end
    end

    // Triggers coincident with a commit are judged against the incoming config.
    assign eff_mode  = cfg_commit ? cfg_mode : act_mode_q;
    assign eff_width = cfg_commit ? cfg_width : act_width_q;
    assign os_abort  = cfg_commit || wd_fault_q;

    always_comb begin
        os_trig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            os_trig[i] = trig[i] && !wd_fault_q &&
                         (dout_mode_t'(eff_mode[MODE_W*i +: MODE_W]) == MODE_ONESHOT);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dout_oneshot #(
            .CNT_W (CNT_W)
        ) u_oneshot (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .trig  (os_trig[g]),
            .abort (os_abort),
            .width (eff_width),
            .busy  (busy[g]),
            .pulse (os_pulse[g])
        );
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
        if (cfg_commit || (act_period_q == '0) ||
            (pwm_cnt_q >= act_period_q - CNT_W'(1))) begin
            pwm_cnt_d = '0;
        end
    end

    assign pwm_out = (act_period_q != '0) && (pwm_cnt_q < act_width_q);

    // A zero timeout expires on the first enabled cycle.
    assign wd_expire = wd_enable && !wd_kick &&
                       ((wd_timeout == '0) || (wd_cnt_q >= wd_timeout - CNT_W'(1)));

    always_comb begin
        wd_cnt_d   = wd_cnt_q;
        wd_fault_d = wd_fault_q;
        if (wd_clear) begin
            wd_cnt_d   = '0;
            wd_fault_d = 1'b0;
        end else if (!wd_enable || wd_kick) begin
            wd_cnt_d = '0;
        end else if (!wd_fault_q) begin
            if (wd_expire) begin
                wd_fault_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        dout_mode_t m;
        m      = MODE_STATIC;
        dout_d = SAFE_VALUE;
        for (int i = 0; i < NUM_CH; i++) begin
            m = dout_mode_t'(act_mode_q[MODE_W*i +: MODE_W]);
            case (m)
                MODE_STATIC:  dout_d[i] = act_level_q[i];
                MODE_ONESHOT: dout_d[i] = act_level_q[i] ^ os_pulse[i];
                MODE_PWM:     dout_d[i] = pwm_out;
                default:      dout_d[i] = SAFE_VALUE[i];
            endcase
        end
        if (wd_fault_q) begin
            dout_d = SAFE_VALUE;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pwm_cnt_q  <= '0;
            wd_cnt_q   <= '0;
            wd_fault_q <= 1'b0;
            dout_q     <= SAFE_VALUE;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            wd_fault_q <= wd_fault_d;
            dout_q     <= dout_d;
        end
    end

    assign dout     = dout_q;
    assign wd_fault = wd_fault_q;

endmodule

// File: tb/tb_dout_channel_driver.sv
// Directed self-checking bench for dout_channel_driver with a queue of expected outputs.
module tb_dout_channel_driver;

    logic        ACLK;
    logic        ARESETN;
    logic [7:0]  cfg_level;
    logic [15:0] cfg_mode;
    logic [31:0] cfg_width;
    logic [31:0] cfg_period;
    logic        cfg_commit;
    logic [7:0]  trig;
    logic        wd_enable;
    logic [31:0] wd_timeout;
    logic        wd_kick;
    logic        wd_clear;
    logic [7:0]  dout;
    logic [7:0]  busy;
    logic        wd_fault;

    typedef struct {
        string      tag;
        logic [7:0] d;
        logic [7:0] b;
        logic       f;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    dout_channel_driver #(
        .NUM_CH     (8),
        .CNT_W      (32),
        .SAFE_VALUE (8'h00)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .cfg_level  (cfg_level),
        .cfg_mode   (cfg_mode),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_commit (cfg_commit),
        .trig       (trig),
        .wd_enable  (wd_enable),
        .wd_timeout (wd_timeout),
        .wd_kick    (wd_kick),
        .wd_clear   (wd_clear),
        .dout       (dout),
        .busy       (busy),
        .wd_fault   (wd_fault)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic cmp(input string tag, input logic [7:0] d, input logic [7:0] b,
                       input logic f);
        checks++;
        assert (dout === d) else begin
            errors++;
            $error("FAIL %s dout observed %h expected %h", tag, dout, d);
        end
        checks++;
        assert (busy === b) else begin
            errors++;
            $error("FAIL %s busy observed %h expected %h", tag, busy, b);
        end
        checks++;
        assert (wd_fault === f) else begin
            errors++;
            $error("FAIL %s wd_fault observed %b expected %b", tag, wd_fault, f);
        end
    endtask

    // Queue the outputs expected after the next edge, clock it, then pop and compare.
    task automatic step(input string tag, input logic [7:0] d, input logic [7:0] b,
                        input logic f);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.b   = b;
        e.f   = f;
        sb.push_back(e);
        @(posedge ACLK);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
        end else begin
            e = sb.pop_front();
            cmp(e.tag, e.d, e.b, e.f);
        end
    endtask

    initial begin
        ARESETN    = 1'b0;
        cfg_level  = 8'h00;
        cfg_mode   = 16'h0000;
        cfg_width  = 32'd0;
        cfg_period = 32'd0;
        cfg_commit = 1'b0;
        trig       = 8'h00;
        wd_enable  = 1'b0;
        wd_timeout = 32'd0;
        wd_kick    = 1'b0;
        wd_clear   = 1'b0;

        repeat (2) @(posedge ACLK);
        #1;
        cmp("reset", 8'h00, 8'h00, 1'b0);
        ARESETN   = 1'b1;
        cfg_level = 8'hA5;
        step("no_commit", 8'h00, 8'h00, 1'b0);
        step("no_commit2", 8'h00, 8'h00, 1'b0);

        // Static commit
        cfg_level  = 8'h5A;
        cfg_commit = 1'b1;
        step("static_commit_edge", 8'h00, 8'h00, 1'b0);
        cfg_commit = 1'b0;
        step("static_commit", 8'h5A, 8'h00, 1'b0);
        cfg_level = 8'hFF;
        step("static_hold", 8'h5A, 8'h00, 1'b0);

        // One-shot on ch0, width 5; ch1 is static so its trigger is ignored
        cfg_level  = 8'h5A;
        cfg_mode   = 16'h0001;
        cfg_width  = 32'd5;
        cfg_commit = 1'b1;
        step("os_commit", 8'h5A, 8'h00, 1'b0);
        cfg_commit = 1'b0;
        step("os_idle", 8'h5A, 8'h00, 1'b0);
        trig = 8'h03;
        step("os_trig", 8'h5A, 8'h01, 1'b0);
        trig = 8'h00;
        step("os_pulse1", 8'h5B, 8'h01, 1'b0);
        trig = 8'h01;
        step("os_retrig", 8'h5B, 8'h01, 1'b0);
        trig = 8'h00;
        for (int n = 3; n <= 5; n++) step("os_pulse", 8'h5B, 8'h01, 1'b0);
        step("os_end", 8'h5A, 8'h00, 1'b0);
        step("os_idle2", 8'h5A, 8'h00, 1'b0);

        // PWM on ch3: period 10, width 3
        cfg_level  = 8'h00;
        cfg_mode   = 16'h0080;
        cfg_width  = 32'd3;
        cfg_period = 32'd10;
        cfg_commit = 1'b1;
        step("pwm_commit", 8'h5A, 8'h00, 1'b0);
        cfg_commit = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step("pwm_3_10", (((n - 1) % 10) < 3) ? 8'h08 : 8'h00, 8'h00, 1'b0);
        end
        cfg_width  = 32'd12;
        cfg_commit = 1'b1;
        step("pwm_commit_w12", 8'h08, 8'h00, 1'b0);
        cfg_commit = 1'b0;
        for (int n = 1; n <= 12; n++) step("pwm_w_ge_p", 8'h08, 8'h00, 1'b0);
        cfg_period = 32'd0;
        cfg_commit = 1'b1;
        step("pwm_commit_p0", 8'h08, 8'h00, 1'b0);
        cfg_commit = 1'b0;
        for (int n = 1; n <= 12; n++) step("pwm_p0", 8'h00, 8'h00, 1'b0);

        // SAFE mode on ch7, then all static high
        cfg_level  = 8'hFF;
        cfg_mode   = 16'hC000;
        cfg_width  = 32'd0;
        cfg_commit = 1'b1;
        step("safe_commit", 8'h00, 8'h00, 1'b0);
        cfg_commit = 1'b0;
        step("safe_mode", 8'h7F, 8'h00, 1'b0);
        cfg_mode   = 16'h0000;
        cfg_commit = 1'b1;
        step("ff_commit", 8'h7F, 8'h00, 1'b0);
        cfg_commit = 1'b0;
        step("static_ff", 8'hFF, 8'h00, 1'b0);

        // Watchdog expiry after 20 unkicked cycles
        wd_timeout = 32'd20;
        wd_enable  = 1'b1;
        for (int n = 1; n <= 19; n++) step("wd_run", 8'hFF, 8'h00, 1'b0);
        step("wd_expire", 8'hFF, 8'h00, 1'b1);
        step("wd_safe", 8'h00, 8'h00, 1'b1);
        wd_kick = 1'b1;
        step("wd_kick_sticky", 8'h00, 8'h00, 1'b1);
        wd_kick  = 1'b0;
        wd_clear = 1'b1;
        step("wd_clear", 8'h00, 8'h00, 1'b0);
        wd_clear = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            wd_kick = ((n % 15) == 0);
            step("wd_kicked", 8'hFF, 8'h00, 1'b0);
        end
        wd_kick    = 1'b0;
        wd_timeout = 32'd0;
        step("wd_to0", 8'hFF, 8'h00, 1'b1);
        step("wd_to0_safe", 8'h00, 8'h00, 1'b1);
        wd_clear  = 1'b1;
        wd_enable = 1'b0;
        step("wd_clear2", 8'h00, 8'h00, 1'b0);
        wd_clear = 1'b0;
        step("wd_resume", 8'hFF, 8'h00, 1'b0);

        // Reset in the middle of a long one-shot on ch1
        cfg_level  = 8'h00;
        cfg_mode   = 16'h0004;
        cfg_width  = 32'd100;
        cfg_commit = 1'b1;
        step("rst_commit", 8'hFF, 8'h00, 1'b0);
        cfg_commit = 1'b0;
        step("rst_idle", 8'h00, 8'h00, 1'b0);
        trig = 8'h02;
        step("rst_trig", 8'h00, 8'h02, 1'b0);
        trig = 8'h00;
        for (int n = 1; n <= 39; n++) step("rst_pulse", 8'h02, 8'h02, 1'b0);
        #2;
        ARESETN = 1'b0;
        #1;
        cmp("rst_async", 8'h00, 8'h00, 1'b0);
        step("rst_held", 8'h00, 8'h00, 1'b0);
        step("rst_held2", 8'h00, 8'h00, 1'b0);
        ARESETN = 1'b1;
        trig    = 8'h02;
        step("rst_cfg_lost", 8'h00, 8'h00, 1'b0);
        trig = 8'h00;
        step("rst_idle_after", 8'h00, 8'h00, 1'b0);
        step("rst_idle_after2", 8'h00, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
